// File: rtl/lsu_mmio.sv
// Load-store unit with memory-mapped I/O: byte-addressable data memory,
// HEX/LEDR/LEDG/LCD output registers and a synchronised switch input behind
// a valid/ready request channel with a one-entry response register.
module lsu_mmio #(
    parameter int unsigned DMEM_BYTES  = 2048,
    parameter int unsigned NUM_HEX     = 8,
    parameter int unsigned SW_WIDTH    = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_addr_i,
    input  logic                   req_we_i,
    input  logic [1:0]             req_size_i,
    input  logic                   req_unsigned_i,
    input  logic [31:0]            req_wdata_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    input  logic [SW_WIDTH-1:0]    io_sw_i,
    output logic [32*NUM_HEX-1:0]  io_hex_o,
    output logic [31:0]            io_ledr_o,
    output logic [31:0]            io_ledg_o,
    output logic [31:0]            io_lcd_o
);

    localparam int unsigned AW = (DMEM_BYTES > 4) ? $clog2(DMEM_BYTES) : 2;

    logic [7:0]                         dmem [DMEM_BYTES];
    logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync;

    logic [11:0]   addr;
    logic [1:0]    off;
    logic [AW-1:0] dmem_base;
    logic          is_dmem, is_hex, is_ledr, is_ledg, is_lcd, is_sw;
    logic          mapped, misalign, acc_err;
    logic [3:0]    be;
    logic [31:0]   wdata_sh, rword, rshift, ldata;
    logic          accept, wr_en;

    assign addr        = req_addr_i[11:0];
    assign off         = addr[1:0];
    assign dmem_base   = AW'({addr[11:2], 2'b00});
    assign req_ready_o = !rsp_valid_o || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o && !rst_i;
    assign wr_en       = accept && req_we_i && !acc_err;

    // Merge new byte lanes into an existing register value.
    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  lanes);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Address decode, error classification and store lane alignment.
    always_comb begin
        is_dmem  = 32'(addr) < DMEM_BYTES;
        is_hex   = (addr[11:7] == 5'b10000) && (addr[3:2] == 2'b00)
                   && (32'(addr[6:4]) < NUM_HEX);
        is_ledr  = addr[11:2] == 10'h220;
        is_ledg  = addr[11:2] == 10'h224;
        is_lcd   = addr[11:2] == 10'h228;
        is_sw    = addr[11:2] == 10'h240;
        mapped   = is_dmem || is_hex || is_ledr || is_ledg || is_lcd || is_sw;
        misalign = ((req_size_i == 2'b01) && off[0])
                   || ((req_size_i == 2'b10) && (off != 2'b00));
        acc_err  = (|req_addr_i[31:12]) || !mapped || (req_size_i == 2'b11)
                   || misalign || (req_we_i && is_sw);
        case (req_size_i)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        wdata_sh = req_wdata_i << {off, 3'b000};
    end

    // Read the aligned word containing the access, then align and extend.
    always_comb begin
        rword = '0;
        if (is_dmem) begin
            for (int i = 0; i < 4; i++) rword[8*i +: 8] = dmem[dmem_base | AW'(i)];
        end
        for (int k = 0; k < NUM_HEX; k++) begin
            if (is_hex && (addr[6:4] == 3'(k))) rword = io_hex_o[32*k +: 32];
        end
        if (is_ledr) rword = io_ledr_o;
        if (is_ledg) rword = io_ledg_o;
        if (is_lcd)  rword = io_lcd_o;
        if (is_sw)   rword = 32'(sw_sync[SYNC_STAGES-1]);
        rshift = rword >> {off, 3'b000};
        case (req_size_i)
            2'b00:   ldata = req_unsigned_i ? {24'd0, rshift[7:0]}
                                            : {{24{rshift[7]}}, rshift[7:0]};
            2'b01:   ldata = req_unsigned_i ? {16'd0, rshift[15:0]}
                                            : {{16{rshift[15]}}, rshift[15:0]};
            default: ldata = rshift;
        endcase
    end

    // Data memory byte-lane writes; contents are not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en && is_dmem) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) dmem[dmem_base | AW'(i)] <= wdata_sh[8*i +: 8];
            end
        end
    end

    // Peripheral output registers, updated only by accepted stores.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            io_hex_o  <= '0;
            io_ledr_o <= '0;
            io_ledg_o <= '0;
            io_lcd_o  <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < NUM_HEX; k++) begin
                if (is_hex && (addr[6:4] == 3'(k)))
                    io_hex_o[32*k +: 32] <= merge(io_hex_o[32*k +: 32], wdata_sh, be);
            end
            if (is_ledr) io_ledr_o <= merge(io_ledr_o, wdata_sh, be);
            if (is_ledg) io_ledg_o <= merge(io_ledg_o, wdata_sh, be);
            if (is_lcd)  io_lcd_o  <= merge(io_lcd_o, wdata_sh, be);
        end
    end

    // Switch input synchroniser chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) sw_sync <= '0;
        else       sw_sync <= {sw_sync[SYNC_STAGES-2:0], io_sw_i};
    end

    // One-entry response register; holds while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (accept) begin
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= acc_err;
            rsp_rdata_o <= (acc_err || req_we_i) ? '0 : ldata;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

endmodule
